// File: rtl/piano_pkg.sv
// Shared constants and key-selection helper for the DE0 piano keypad and tone generator.
package piano_pkg;

   localparam int unsigned NUM_KEYS      = 8;
   localparam int unsigned CODE_W        = 3;
   localparam int unsigned DEBOUNCE_20MS = 1_000_000;

   localparam int unsigned KEY_C_LO = 7;
   localparam int unsigned KEY_D    = 6;
   localparam int unsigned KEY_E    = 5;
   localparam int unsigned KEY_F    = 4;
   localparam int unsigned KEY_G    = 3;
   localparam int unsigned KEY_A    = 2;
   localparam int unsigned KEY_B    = 1;
   localparam int unsigned KEY_C_HI = 0;

   typedef struct packed {
      logic [NUM_KEYS-1:0] onehot;
      logic [CODE_W-1:0]   code;
      logic                valid;
   } key_sel_t;

   // Lowest set index wins: scanning downward lets the last hit override.
   function automatic key_sel_t key_select(input logic [NUM_KEYS-1:0] held);
      key_sel_t sel;
      sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (held[i]) begin
            sel.onehot    = '0;
            sel.onehot[i] = 1'b1;
            sel.code      = CODE_W'(i);
            sel.valid     = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/piano_keypad_debounce.sv
// Single key channel: 2-flop synchroniser, polarity normalisation and stability counter.
module key_debounce
   import piano_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned RAW_ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);

   localparam int unsigned   CntW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic          RelLevel = (RAW_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [1:0]      sync_q;
   logic            level;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // XOR with the released level maps the pin onto pressed=1.
   assign level = sync_q[1] ^ RelLevel;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (level == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         stable_d = ~stable_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= {2{RelLevel}};
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], raw};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/piano_keypad.sv
// Debounced, priority-reduced one-hot key vector with code, valid and press strobe.
module piano_keypad
   import piano_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned RAW_ACTIVE_LOW  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   output logic                key_press
);

   logic [NUM_KEYS-1:0] stable;
   key_sel_t            sel;
   logic [NUM_KEYS-1:0] key_q;
   logic [CODE_W-1:0]   code_q;
   logic                valid_q;
   logic                press_q, press_d;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
      ) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .raw   (key_raw[g]),
         .stable(stable[g])
      );
   end

   always_comb begin
      sel     = key_select(stable);
      press_d = sel.valid && (sel.onehot != key_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         key_q   <= sel.onehot;
         code_q  <= sel.code;
         valid_q <= sel.valid;
         press_q <= press_d;
      end
   end

   assign key       = key_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_press = press_q;

endmodule
